// File: rtl/bus_arbiter_pkg.sv
// Shared snoopy-bus command/ID encodings plus the types and helpers used by bus_arbiter.
`ifndef BUS_DEFINES_SVH
`define BUS_DEFINES_SVH
`define CMD_BUSRD       3'd0
`define CMD_BUSRDX      3'd1
`define CMD_BUSUPGR     3'd2
`define CMD_FILL        3'd3
`define CMD_FLUSH       3'd4
`define BUSID_L2_0      2'd0
`define BUSID_L2_1      2'd1
`define BUSID_L2_2      2'd2
`define BUSID_MEM       2'd3
`define BUS_SLOT_CYCLES 8
`endif

package bus_arbiter_pkg;
    localparam int CMD_W  = 3;
    localparam int TAG_W  = 5;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 64;
    localparam logic [2:0] LAST_CYCLE = 3'(`BUS_SLOT_CYCLES - 1);

    typedef enum logic [CMD_W-1:0] {
        CMD_BUSRD   = `CMD_BUSRD,
        CMD_BUSRDX  = `CMD_BUSRDX,
        CMD_BUSUPGR = `CMD_BUSUPGR,
        CMD_FILL    = `CMD_FILL,
        CMD_FLUSH   = `CMD_FLUSH
    } cmd_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
    } slot_t;

    // Fill/Flush are responses; they win over new requests so that responses always drain.
    function automatic logic is_response(input logic [CMD_W-1:0] cmd);
        return (cmd == `CMD_FILL) || (cmd == `CMD_FLUSH);
    endfunction
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);
    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        gnt   = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N))
                sum = sum - SW'(N);
            idx = sum[PW-1:0];
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Slotted snoopy-bus arbiter: one owner per 8-cycle slot, response-class priority, merged snoop result.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [CMD_W*NREQ-1:0]    req_cmd,
    input  logic [TAG_W*NREQ-1:0]    req_tag,
    input  logic [ADDR_W*NREQ-1:0]   req_addr,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_gnt,
    input  logic [NREQ-1:0]          snoop_hit,
    input  logic [NREQ-1:0]          snoop_nack,
    output logic                     bus_valid,
    output logic [CMD_W-1:0]         bus_cmd,
    output logic [TAG_W-1:0]         bus_tag,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_data,
    output logic [2:0]               bus_cycle,
    output logic [NREQ-1:0]          resp_valid,
    output logic                     resp_hit,
    output logic                     resp_nack
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic            owner_valid;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr;
    slot_t           slot;
    logic            acc_hit, acc_nack;

    logic [NREQ-1:0] owner_oh, eligible, high;
    logic [NREQ-1:0] high_gnt, all_gnt, win_oh;
    logic            high_valid, all_valid, win_valid;
    logic [PW-1:0]   win_idx, next_ptr;
    slot_t           win_slot;
    logic            hit_now, nack_now;

    always_comb begin
        owner_oh = '0;
        bus_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_valid && owner == PW'(i)) begin
                owner_oh[i] = 1'b1;
                bus_data    = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The current owner sits out the next slot: its nack is only known after this edge.
    assign eligible = req_valid & ~owner_oh;

    always_comb begin
        high = '0;
        for (int i = 0; i < NREQ; i++)
            high[i] = eligible[i] && is_response(req_cmd[i*CMD_W +: CMD_W]);
    end

    rr_pick #(.N(NREQ)) u_pick_high (.req(high),     .ptr(ptr), .gnt(high_gnt), .valid(high_valid));
    rr_pick #(.N(NREQ)) u_pick_all  (.req(eligible), .ptr(ptr), .gnt(all_gnt),  .valid(all_valid));

    assign win_oh    = high_valid ? high_gnt : all_gnt;
    assign win_valid = high_valid | all_valid;

    always_comb begin
        win_idx  = '0;
        win_slot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = PW'(i);
                win_slot = '{cmd:  req_cmd[i*CMD_W +: CMD_W],
                             tag:  req_tag[i*TAG_W +: TAG_W],
                             addr: req_addr[i*ADDR_W +: ADDR_W]};
            end
        end
    end

    assign next_ptr = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);

    // Idle slots must not collect snoop results, since ~owner_oh is all ones there.
    assign hit_now  = owner_valid && |(snoop_hit  & ~owner_oh);
    assign nack_now = owner_valid && |(snoop_nack & ~owner_oh);

    assign req_gnt   = (bus_cycle == LAST_CYCLE) ? win_oh : '0;
    assign bus_valid = owner_valid;
    assign bus_cmd   = slot.cmd;
    assign bus_tag   = slot.tag;
    assign bus_addr  = slot.addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_cycle   <= '0;
            owner_valid <= 1'b0;
            owner       <= '0;
            ptr         <= '0;
            slot        <= '0;
            acc_hit     <= 1'b0;
            acc_nack    <= 1'b0;
            resp_valid  <= '0;
            resp_hit    <= 1'b0;
            resp_nack   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            bus_cycle  <= bus_cycle + 3'd1;
            resp_valid <= '0;
            resp_hit   <= 1'b0;
            resp_nack  <= 1'b0;
            if (bus_cycle == LAST_CYCLE) begin
                resp_valid  <= owner_oh;
                resp_hit    <= acc_hit | hit_now;
                resp_nack   <= acc_nack | nack_now;
                acc_hit     <= 1'b0;
                acc_nack    <= 1'b0;
                owner_valid <= win_valid;
                owner       <= win_idx;
                slot        <= win_slot;
                if (win_valid)
                    ptr <= next_ptr;
            end else begin
                acc_hit  <= acc_hit | hit_now;
                acc_nack <= acc_nack | nack_now;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: slot timing, round-robin, response priority, snoop merge, reset.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int NREQ = 4;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [3*NREQ-1:0]      req_cmd;
    logic [5*NREQ-1:0]      req_tag;
    logic [26*NREQ-1:0]     req_addr;
    logic [64*NREQ-1:0]     req_data;
    logic [NREQ-1:0]        req_gnt;
    logic [NREQ-1:0]        snoop_hit;
    logic [NREQ-1:0]        snoop_nack;
    logic                   bus_valid;
    logic [2:0]             bus_cmd;
    logic [4:0]             bus_tag;
    logic [25:0]            bus_addr;
    logic [63:0]            bus_data;
    logic [2:0]             bus_cycle;
    logic [NREQ-1:0]        resp_valid;
    logic                   resp_hit;
    logic                   resp_nack;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_tag(req_tag),
        .req_addr(req_addr), .req_data(req_data), .req_gnt(req_gnt),
        .snoop_hit(snoop_hit), .snoop_nack(snoop_nack),
        .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_tag(bus_tag),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_cycle(bus_cycle),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_nack(resp_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] cmd, input logic [4:0] tag,
                           input logic [25:0] addr);
        req_cmd[i*3 +: 3]   = cmd;
        req_tag[i*5 +: 5]   = tag;
        req_addr[i*26 +: 26] = addr;
    endtask

    // Advances at least one cycle, then to the next negedge where bus_cycle == c.
    task automatic wait_cyc(input logic [2:0] c);
        int n;
        n = 0;
        @(negedge clk);
        while (bus_cycle != c && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_cycle", 64'(bus_cycle), 64'(c));
    endtask

    function automatic logic [63:0] beat(input int k);
        return 64'hDA7A_0002_0000_0000 | 64'(k);
    endfunction

    logic [3:0] rr_order [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_cmd    = '0;
        req_tag    = '0;
        req_addr   = '0;
        req_data   = '0;
        snoop_hit  = '0;
        snoop_nack = '0;

        // Reset state, with requester 0 already presenting BusRd.
        set_req(0, CMD_BUSRD, 5'h01, 26'h123);
        req_valid = 4'b0001;
        repeat (2) @(negedge clk);
        check("rst_bus_cycle",  64'(bus_cycle), 0);
        check("rst_bus_valid",  64'(bus_valid), 0);
        check("rst_bus_addr",   64'(bus_addr), 0);
        check("rst_req_gnt",    64'(req_gnt), 0);
        check("rst_resp_valid", 64'(resp_valid), 0);
        rst = 1'b0;

        // Single requester: granted at the first cycle 7, owns the second slot.
        wait_cyc(3'd7);
        check("t1_first_gnt", 64'(req_gnt), 64'(4'b0001));
        check("t1_idle_first_slot", 64'(bus_valid), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t1_cycle", 64'(bus_cycle), 64'(k));
            check("t1_bus_valid", 64'(bus_valid), 1);
            check("t1_bus_addr", 64'(bus_addr), 64'(26'h123));
            if (k == 7) check("t1_owner_masked", 64'(req_gnt), 0);
            snoop_hit = (k == 2) ? 4'b0010 : 4'b0000;
        end
        @(negedge clk);
        check("t1_resp_valid", 64'(resp_valid), 64'(4'b0001));
        check("t1_resp_nack", 64'(resp_nack), 0);
        check("t1_resp_hit", 64'(resp_hit), 1);
        check("t1_idle_after", 64'(bus_valid), 0);

        // All four requesting; pointer is 1 after the grant to 0.
        req_valid = 4'b1111;
        for (int i = 1; i < 4; i++) set_req(i, CMD_BUSRD, 5'(i), 26'(16 * i));
        for (int s = 0; s < 6; s++) begin
            wait_cyc(3'd7);
            check("t2_rr_gnt", 64'(req_gnt), 64'(rr_order[s]));
            wait_cyc(3'd0);
            check("t2_bus_valid", 64'(bus_valid), 1);
            check("t2_resp_valid", 64'(resp_valid), (s == 0) ? 64'd0 : 64'(rr_order[s-1]));
        end
        req_valid = '0;
        wait_cyc(3'd7);
        check("t2_no_gnt", 64'(req_gnt), 0);
        wait_cyc(3'd0);
        check("t2_last_resp", 64'(resp_valid), 64'(4'b0100));
        check("t2_idle", 64'(bus_valid), 0);

        // Response priority: pointer moved to 1 by a grant to 0, then 1 (BusRdX) vs 2 (Flush).
        req_valid = 4'b0001;
        wait_cyc(3'd7);
        check("t3_gnt0", 64'(req_gnt), 64'(4'b0001));
        wait_cyc(3'd0);
        set_req(1, CMD_BUSRDX, 5'h09, 26'h2AA);
        set_req(2, CMD_FLUSH,  5'h15, 26'h3BB);
        req_valid = 4'b0111;
        wait_cyc(3'd7);
        check("t3_flush_first", 64'(req_gnt), 64'(4'b0100));
        wait_cyc(3'd0);
        check("t3_resp0", 64'(resp_valid), 64'(4'b0001));
        check("t3_bus_cmd", 64'(bus_cmd), 64'(CMD_FLUSH));
        check("t3_bus_tag", 64'(bus_tag), 64'(5'h15));
        req_valid = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            req_data[2*64 +: 64] = beat(k);
            #1;
            check("t3_beat_cycle", 64'(bus_cycle), 64'(k));
            check("t3_bus_data", bus_data, beat(k));
            if (k == 7) check("t3_gnt1", 64'(req_gnt), 64'(4'b0010));
        end
        @(negedge clk);
        check("t3_resp2", 64'(resp_valid), 64'(4'b0100));
        check("t3_bus_cmd1", 64'(bus_cmd), 64'(CMD_BUSRDX));
        check("t3_bus_addr1", 64'(bus_addr), 64'(26'h2AA));
        req_valid = 4'b0010;
        wait_cyc(3'd7);
        check("t3_owner1_masked", 64'(req_gnt), 0);
        wait_cyc(3'd0);
        check("t3_resp1", 64'(resp_valid), 64'(4'b0010));
        req_valid = '0;

        // Snoop merge for owner 0: non-owner nacks in cycles 3 and 6, owner's own hit ignored.
        req_valid = 4'b0001;
        wait_cyc(3'd7);
        check("t4_gnt0", 64'(req_gnt), 64'(4'b0001));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            snoop_hit  = 4'b0001;
            snoop_nack = (k == 3) ? 4'b0100 : (k == 6) ? 4'b1000 : 4'b0000;
            #1;
            if (k == 7) check("t4_no_back_to_back", 64'(req_gnt), 0);
        end
        @(negedge clk);
        check("t4_resp_valid", 64'(resp_valid), 64'(4'b0001));
        check("t4_resp_nack", 64'(resp_nack), 1);
        check("t4_resp_hit", 64'(resp_hit), 0);
        snoop_hit  = '0;
        snoop_nack = '0;
        wait_cyc(3'd7);
        check("t4_regrant", 64'(req_gnt), 64'(4'b0001));

        // Reset mid-slot; afterwards the pointer is 0 again so 0 beats 3.
        wait_cyc(3'd4);
        check("t5_owned", 64'(bus_valid), 1);
        rst = 1'b1;
        set_req(3, CMD_BUSRD, 5'h0B, 26'h77);
        req_valid = 4'b1001;
        #1;
        check("t5_bus_valid_drop", 64'(bus_valid), 0);
        check("t5_cycle_clear", 64'(bus_cycle), 0);
        check("t5_addr_clear", 64'(bus_addr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_restart_cycle", 64'(bus_cycle), 0);
        check("t5_no_resp", 64'(resp_valid), 0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check("t5_cycle", 64'(bus_cycle), 64'(k));
            check("t5_no_resp", 64'(resp_valid), 0);
            check("t5_idle", 64'(bus_valid), 0);
        end
        check("t5_gnt_ptr0", 64'(req_gnt), 64'(4'b0001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Owns the shared snoopy bus seen by each L2's bus receiver, L2 transmitter and the memory controller.
- Time is divided into fixed 8-cycle slots; one requester is granted per slot and drives cmd/tag/addr for the whole slot plus 8 data beats.
- The block merges every agent's hit/nack snoop result and returns the merged result to the slot owner.
- Fill/Flush traffic has priority over new BusRd/BusRdX/BusUpgr requests, so responses always drain.

Parameters:
NREQ, 4, number of bus requesters (agents); all per-requester buses are packed, requester i at slice i.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  NREQ  requester i has a transaction pending
req_cmd  in  3*NREQ  bus command (`CMD_*); stable while req_valid
req_tag  in  5*NREQ  {busid, 3-bit txn tag}; stable while req_valid
req_addr  in  26*NREQ  line address [31:6]; stable while req_valid
req_data  in  64*NREQ  data beat for the current bus_cycle (Fill/Flush only)
req_gnt  out  NREQ  one-hot one-cycle grant pulse
snoop_hit  in  NREQ  per-agent l2_bus_hit
snoop_nack  in  NREQ  per-agent l2_bus_nack
bus_valid  out  1  slot carries a transaction
bus_cmd  out  3  command of current slot
bus_tag  out  5  tag of current slot
bus_addr  out  26  address of current slot
bus_data  out  64  data beat of current slot
bus_cycle  out  3  position within slot (0..7)
resp_valid  out  NREQ  one-hot, one cycle: the owner's slot result is available
resp_hit  out  1  OR of non-owner snoop_hit for that slot
resp_nack  out  1  OR of non-owner snoop_nack for that slot; the owner must retry

Behaviour:
- Reset values:
  - bus_cycle=0; bus_valid=0; bus_cmd/tag/addr/data=0.
  - req_gnt=0; resp_valid=0; resp_hit=0; resp_nack=0.
  - Round-robin pointer=0; no slot owner.
  - All agents release reset together, so their slot counters stay aligned with bus_cycle.
- bus_cycle is a free-running 3-bit counter that wraps 7->0. The first slot after reset is always idle.
- Arbitration happens only in the cycle with bus_cycle==7.
- Eligible set: req_valid masked by the current slot's owner. A slot owner cannot win the immediately following slot, because its nack is not yet known.
- High class: eligible requesters whose req_cmd is `CMD_FILL or `CMD_FLUSH. If the high class is non-empty, pick from it; otherwise pick from all eligible requesters.
- Within a class, round-robin starts at the pointer, with index wrap NREQ-1 -> 0. After a grant to i, pointer = (i+1) mod NREQ. The pointer is unchanged on idle slots.
- Grant:
  - req_gnt[i] pulses in that same bus_cycle==7 cycle.
  - On the clock edge, the arbiter registers owner, cmd, tag and addr.
  - The requester keeps req_* stable until it sees resp_valid[i].
- Slot (cycles 0..7):
  - bus_valid=1, and bus_cmd/tag/addr hold the registered values.
  - bus_data = req_data slice of the owner, as a combinational mux; the requester indexes its beats by bus_cycle.
  - With no winner, bus_valid=0 and all bus fields are 0 for the whole slot.
- Snoop result:
  - In cycle 7 of an owned slot, latch OR(snoop_hit & ~owner_onehot) and OR(snoop_nack & ~owner_onehot).
  - Next cycle (cycle 0 of the next slot), resp_valid[owner]=1 for exactly one cycle, with resp_hit/resp_nack.
  - Idle slots produce no resp_valid.
- Simultaneous events: in cycle 7, a new grant and the latching of the previous owner's result coincide. The grant uses the pre-edge owner mask; the result belongs to the pre-edge owner.
- Requester behaviour after resp_valid:
  - If resp_nack=1, the requester keeps req_valid and is re-eligible at the next cycle 7.
  - If resp_nack=0, the requester deasserts req_valid or presents its next transaction.
- req_valid dropping while not granted: no effect. If it drops mid-slot after a grant, the slot still completes with the latched fields; bus_data follows the live req_data.
- Reset asserted mid-slot: all outputs return to reset values immediately. The in-flight transaction is lost with no resp_valid, and the pointer clears.

Decomposition:
- Shared defines header (same as the other L2/bus blocks) holds:
  - `CMD_BUSRD, `CMD_BUSRDX, `CMD_BUSUPGR, `CMD_FILL, `CMD_FLUSH;
  - `BUSID_* values;
  - new `BUS_SLOT_CYCLES (8).
- One sub-module: rr_pick (parameter N; inputs req[N], ptr; output one-hot gnt plus valid). It is instantiated twice, once for the high class and once for all eligible requesters, with a final 2:1 select.

Test Plan:
1. Reset release, req_valid=4'b0001, cmd=BUSRD, addr=26'h123 from cycle 0.
   - req_gnt=0001 at the first bus_cycle==7.
   - bus_valid=1, bus_addr=26'h123 for cycles 0..7 of the second slot.
   - resp_valid=0001 with nack=0 at the following cycle 0.
2. All four requesters requesting BUSRD continuously, no nacks.
   - Grants follow the order 0,1,2,3,0,... with one grant per slot.
   - No requester is granted in two consecutive slots.
3. Requester 1 BUSRDX and requester 2 FLUSH, both pending at cycle 7 with pointer=1.
   - Requester 2 is granted first.
   - bus_data equals req_data[2] beat k at bus_cycle=k.
4. Owner 0 while agents 2 and 3 assert snoop_nack in cycles 3 and 6, and agent 0 asserts its own snoop_hit.
   - resp_nack=1, resp_hit=0.
   - Requester 0 is re-granted no earlier than the slot after next.
5. Reset asserted at bus_cycle=4 of an owned slot.
   - bus_valid drops immediately and no resp_valid is issued.
   - After release, bus_cycle restarts at 0 and the next grant comes from pointer 0.
